cpu_multicycle_control: RTL

Multi-cycle LEGv8 control unit: a state machine that sequences each instruction through fetch, decode, execute, memory and write-back, with a ready handshake to instruction/data memory. It drives the same datapath control set as the single-cycle decoder, plus PC/IR write enables and status flags. Memory-wait timeout and handshake mode are parametrised. Sits between the instruction register/memory interface and the datapath in the multi-cycle CPU top.

---
 rtl/cpu_ctrl_pkg.sv | 63 ++++++
 rtl/cpu_multicycle_control_decode.sv | 31 +++
 rtl/cpu_multicycle_control.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle LEGv8 control unit.
// States, opcode patterns, instruction classes and ALU control codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NONE,
        C_LDUR,
        C_STUR,
        C_ADD,
        C_SUB,
        C_AND,
        C_ORR,
        C_ADDI,
        C_CBZ,
        C_CBNZ,
        C_B,
        C_HALT
    } cls_t;

    localparam logic [10:0] MASK_ALL  = 11'b111_1111_1111;
    localparam logic [10:0] MASK_ADDI = 11'b111_1111_1110;
    localparam logic [10:0] MASK_CB   = 11'b111_1111_1000;
    localparam logic [10:0] MASK_B    = 11'b111_1110_0000;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_HALT = 11'b11111111111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] ALUSRC_REG  = 2'b00;
    localparam logic [1:0] ALUSRC_DOFF = 2'b01;
    localparam logic [1:0] ALUSRC_IMM  = 2'b10;

    function automatic logic op_match(
        input logic [10:0] op,
        input logic [10:0] mask,
        input logic [10:0] pat
    );
        return (op & mask) == pat;
    endfunction

endpackage

// File: rtl/cpu_multicycle_control_decode.sv
// Combinational opcode classifier, shared with the single-cycle path.
// Patterns are mutually exclusive, so at most one arm can match.
module cpu_opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output cls_t        cls,
    output logic        illegal
);

    always_comb begin
        cls = C_NONE;
        unique case (1'b1)
            op_match(opcode, MASK_ALL, OP_LDUR):  cls = C_LDUR;
            op_match(opcode, MASK_ALL, OP_STUR):  cls = C_STUR;
            op_match(opcode, MASK_ALL, OP_ADD):   cls = C_ADD;
            op_match(opcode, MASK_ALL, OP_SUB):   cls = C_SUB;
            op_match(opcode, MASK_ALL, OP_AND):   cls = C_AND;
            op_match(opcode, MASK_ALL, OP_ORR):   cls = C_ORR;
            op_match(opcode, MASK_ADDI, OP_ADDI): cls = C_ADDI;
            op_match(opcode, MASK_CB, OP_CBZ):    cls = C_CBZ;
            op_match(opcode, MASK_CB, OP_CBNZ):   cls = C_CBNZ;
            op_match(opcode, MASK_B, OP_B):       cls = C_B;
            op_match(opcode, MASK_ALL, OP_HALT):  cls = C_HALT;
            default:                              cls = C_NONE;
        endcase
    end

    assign illegal = (cls == C_NONE);

endmodule

// File: rtl/cpu_multicycle_control.sv
// Multi-cycle LEGv8 control FSM with memory ready/fixed-latency handshake.
// Controls decode from state and registered class; some strobes are Mealy.
module cpu_multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_LAT       = 1,
    parameter int MEM_TIMEOUT   = 0,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] inst31_21,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        imem_rd,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        Reg2Loc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrc,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q;
    cls_t             cls_q;
    cls_t             dec_cls;
    logic             dec_illegal;
    logic [CNT_W-1:0] cnt_q;
    logic             halted_q;
    logic             illegal_q;
    logic             mem_done;
    logic             timeout;

    cpu_opcode_decode u_dec (
        .opcode  (inst31_21),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    assign mem_done = (MEM_HANDSHAKE != 0) ? mem_ready
                                           : (cnt_q == LAT_LAST);

    // a ready in the final allowed cycle beats the timeout
    assign timeout = (MEM_TIMEOUT != 0) && (MEM_HANDSHAKE != 0) &&
                     !mem_ready && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
            unique case (state_q)
                S_FETCH: begin
                    if (mem_done) begin
                        state_q <= S_DECODE;
                    end else if (timeout) begin
                        state_q   <= S_ERR;
                        illegal_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    cls_q <= dec_cls;
                    if (dec_cls == C_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (dec_illegal) begin
                        state_q   <= S_ERR;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_q <= '0;
                    unique case (cls_q)
                        C_LDUR, C_STUR:     state_q <= S_MEM;
                        C_CBZ, C_CBNZ, C_B: state_q <= S_FETCH;
                        default:            state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_done) begin
                        state_q <= (cls_q == C_LDUR) ? S_WB : S_FETCH;
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q   <= S_ERR;
                        illegal_q <= 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    cnt_q   <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_rd  = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        Reg2Loc  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUOp    = ALUOP_ADD;
        ALUSrc   = ALUSRC_REG;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    imem_rd  = 1'b1;
                    ir_write = mem_done;
                    pc_write = mem_done;
                end
                S_EXEC: begin
                    unique case (cls_q)
                        C_ADD, C_SUB, C_AND, C_ORR: begin
                            ALUOp = ALUOP_RTYPE;
                        end
                        C_ADDI: begin
                            ALUOp  = ALUOP_RTYPE;
                            ALUSrc = ALUSRC_IMM;
                        end
                        C_LDUR: begin
                            ALUSrc = ALUSRC_DOFF;
                        end
                        C_STUR: begin
                            Reg2Loc = 1'b1;
                            ALUSrc  = ALUSRC_DOFF;
                        end
                        C_CBZ, C_CBNZ: begin
                            Reg2Loc  = 1'b1;
                            ALUOp    = ALUOP_PASSB;
                            pc_src   = 1'b1;
                            pc_write = (cls_q == C_CBZ) ? zero : !zero;
                        end
                        C_B: begin
                            pc_src   = 1'b1;
                            pc_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    MemRead  = (cls_q == C_LDUR);
                    MemWrite = (cls_q == C_STUR);
                    ALUSrc   = ALUSRC_DOFF;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (cls_q == C_LDUR);
                end
                default: ;
            endcase
        end
    end

    assign state   = rst ? S_FETCH : state_q;
    assign halted  = halted_q && !rst;
    assign illegal = illegal_q && !rst;

endmodule
